// File: rtl/vx_ipdom_ctrl_pkg.sv
// Shared encodings for the IPDOM reconvergence controller: request opcodes and FSM states.
package vx_ipdom_ctrl_pkg;

   localparam logic IPDOM_OP_SPLIT = 1'b0;
   localparam logic IPDOM_OP_JOIN  = 1'b1;

   typedef enum logic {
      IPDOM_IDLE = 1'b0,
      IPDOM_RESP = 1'b1
   } ipdom_state_e;

endpackage

// File: rtl/vx_ipdom_ctrl_if.sv
// Request/response handshake bundle between the warp scheduler and the IPDOM controller.
interface vx_ipdom_ctrl_if #(
   parameter int NUM_THREADS = 4,
   parameter int PC_WIDTH    = 32
);
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_op;
   logic [NUM_THREADS-1:0] req_tmask;
   logic [NUM_THREADS-1:0] req_pred;
   logic [PC_WIDTH-1:0]    req_pc;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [NUM_THREADS-1:0] rsp_tmask;
   logic [PC_WIDTH-1:0]    rsp_pc;
   logic                   rsp_redirect;
   logic                   rsp_diverged;

   modport master (
      output req_valid, req_op, req_tmask, req_pred, req_pc, rsp_ready,
      input  req_ready, rsp_valid, rsp_tmask, rsp_pc, rsp_redirect, rsp_diverged
   );

   modport slave (
      input  req_valid, req_op, req_tmask, req_pred, req_pc, rsp_ready,
      output req_ready, rsp_valid, rsp_tmask, rsp_pc, rsp_redirect, rsp_diverged
   );

endinterface

// File: rtl/vx_ipdom_ctrl.sv
// IPDOM split/join controller driving an external reconvergence stack.
// Define VX_IPDOM_PERF_EN to add the perf_splits/perf_divergences/perf_joins counters.
module vx_ipdom_ctrl
   import vx_ipdom_ctrl_pkg::*;
#(
   parameter int NUM_THREADS = 4,
   parameter int PC_WIDTH    = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   vx_ipdom_ctrl_if.slave                  bus,
   output logic                            stk_push,
   output logic                            stk_pop,
   output logic                            stk_pair,
   output logic [NUM_THREADS+PC_WIDTH-1:0] stk_q1,
   output logic [NUM_THREADS+PC_WIDTH-1:0] stk_q2,
   input  logic [NUM_THREADS+PC_WIDTH-1:0] stk_d,
   input  logic                            stk_index,
   input  logic                            stk_empty,
   input  logic                            stk_full,
   output logic                            err_overflow,
   output logic                            err_underflow
`ifdef VX_IPDOM_PERF_EN
   ,
   output logic [31:0]                     perf_splits,
   output logic [31:0]                     perf_divergences,
   output logic [31:0]                     perf_joins
`endif
);

   ipdom_state_e           state_q, state_d;
   logic                   accept, is_split, divergent;
   logic [NUM_THREADS-1:0] taken, ntaken;

   logic [NUM_THREADS-1:0] rsp_tmask_p0, rsp_tmask_p1;
   logic [PC_WIDTH-1:0]    rsp_pc_p0, rsp_pc_p1;
   logic                   rsp_redirect_p0, rsp_redirect_p1;
   logic                   rsp_diverged_p0, rsp_diverged_p1;

   assign taken     = bus.req_tmask & bus.req_pred;
   assign ntaken    = bus.req_tmask & ~bus.req_pred;
   assign divergent = (|taken) && (|ntaken);
   assign is_split  = (bus.req_op == IPDOM_OP_SPLIT);
   assign accept    = bus.req_valid && bus.req_ready;

   // Stack commands are combinational pulses in the accept cycle only.
   assign stk_push = accept && is_split && !stk_full;
   assign stk_pop  = accept && !is_split && !stk_empty;
   assign stk_pair = stk_push && divergent;
   assign stk_q1   = {bus.req_tmask, bus.req_pc};
   assign stk_q2   = {ntaken, bus.req_pc};

   always_comb begin
      state_d       = state_q;
      bus.req_ready = 1'b0;
      case (state_q)
         IPDOM_IDLE: begin
            bus.req_ready = !reset;
            if (bus.req_valid && !reset) state_d = IPDOM_RESP;
         end
         IPDOM_RESP: begin
            if (bus.rsp_ready) state_d = IPDOM_IDLE;
         end
         default: state_d = IPDOM_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IPDOM_IDLE;
      else       state_q <= state_d;
   end

   // p0: response fields resolved from request and stack read in the accept cycle
   always_comb begin
      rsp_tmask_p0    = '0;
      rsp_pc_p0       = '0;
      rsp_redirect_p0 = 1'b0;
      rsp_diverged_p0 = 1'b0;
      if (is_split) begin
         rsp_pc_p0 = bus.req_pc;
         if (stk_full) begin
            rsp_tmask_p0 = bus.req_tmask;
         end else if (divergent) begin
            rsp_tmask_p0    = taken;
            rsp_diverged_p0 = 1'b1;
         end else begin
            rsp_tmask_p0 = (|taken) ? taken : ntaken;
         end
      end else if (!stk_empty) begin
         {rsp_tmask_p0, rsp_pc_p0} = stk_d;
         rsp_redirect_p0           = !stk_index;
      end
   end

   // p1: held response, stable until the consumer takes it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_tmask_p1    <= '0;
         rsp_pc_p1       <= '0;
         rsp_redirect_p1 <= 1'b0;
         rsp_diverged_p1 <= 1'b0;
         err_overflow    <= 1'b0;
         err_underflow   <= 1'b0;
      end else if (accept) begin
         rsp_tmask_p1    <= rsp_tmask_p0;
         rsp_pc_p1       <= rsp_pc_p0;
         rsp_redirect_p1 <= rsp_redirect_p0;
         rsp_diverged_p1 <= rsp_diverged_p0;
         if (is_split && stk_full)   err_overflow  <= 1'b1;
         if (!is_split && stk_empty) err_underflow <= 1'b1;
      end
   end

   assign bus.rsp_valid    = (state_q == IPDOM_RESP);
   assign bus.rsp_tmask    = rsp_tmask_p1;
   assign bus.rsp_pc       = rsp_pc_p1;
   assign bus.rsp_redirect = rsp_redirect_p1;
   assign bus.rsp_diverged = rsp_diverged_p1;

`ifdef VX_IPDOM_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_splits      <= '0;
         perf_divergences <= '0;
         perf_joins       <= '0;
      end else if (accept) begin
         if (is_split) perf_splits <= perf_splits + 32'd1;
         if (is_split && !stk_full && divergent) perf_divergences <= perf_divergences + 32'd1;
         if (!is_split) perf_joins <= perf_joins + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vx_ipdom_ctrl.sv
// Directed self-checking bench for vx_ipdom_ctrl with a bench-driven stack model.
module tb_vx_ipdom_ctrl;
   import vx_ipdom_ctrl_pkg::*;

   localparam int NT = 4;
   localparam int PW = 32;
   localparam int EW = NT + PW;

   logic          clk;
   logic          reset;
   logic          stk_push, stk_pop, stk_pair;
   logic [EW-1:0] stk_q1, stk_q2, stk_d;
   logic          stk_index, stk_empty, stk_full;
   logic          err_overflow, err_underflow;
`ifdef VX_IPDOM_PERF_EN
   logic [31:0]   perf_splits, perf_divergences, perf_joins;
`endif

   int checks = 0;
   int errors = 0;

   vx_ipdom_ctrl_if #(.NUM_THREADS(NT), .PC_WIDTH(PW)) bus ();

   vx_ipdom_ctrl #(.NUM_THREADS(NT), .PC_WIDTH(PW)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .stk_push      (stk_push),
      .stk_pop       (stk_pop),
      .stk_pair      (stk_pair),
      .stk_q1        (stk_q1),
      .stk_q2        (stk_q2),
      .stk_d         (stk_d),
      .stk_index     (stk_index),
      .stk_empty     (stk_empty),
      .stk_full      (stk_full),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
`ifdef VX_IPDOM_PERF_EN
      ,
      .perf_splits      (perf_splits),
      .perf_divergences (perf_divergences),
      .perf_joins       (perf_joins)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request mid-cycle so the accept-cycle stack outputs can be sampled.
   task automatic present(input logic op, input logic [NT-1:0] tm, input logic [NT-1:0] pr,
                          input logic [PW-1:0] pc);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_tmask = tm;
      bus.req_pred  = pr;
      bus.req_pc    = pc;
      #1;
   endtask

   task automatic clock_accept();
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic take_rsp(input string tag);
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      chk({tag, "_rsp_done"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, "_ready_again"}, 64'(bus.req_ready), 64'd1);
   endtask

   initial begin
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = IPDOM_OP_SPLIT;
      bus.req_tmask = '0;
      bus.req_pred  = '0;
      bus.req_pc    = '0;
      bus.rsp_ready = 1'b0;
      stk_d         = '0;
      stk_index     = 1'b0;
      stk_empty     = 1'b0;
      stk_full      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_push", 64'(stk_push), 64'd0);
      chk("rst_pop", 64'(stk_pop), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_err_ovf", 64'(err_overflow), 64'd0);
      chk("rst_err_unf", 64'(err_underflow), 64'd0);
      chk("rst_rsp_tmask", 64'(bus.rsp_tmask), 64'd0);

      // Divergent split
      present(IPDOM_OP_SPLIT, 4'b1111, 4'b0011, 32'h100);
      chk("div_push", 64'(stk_push), 64'd1);
      chk("div_pop", 64'(stk_pop), 64'd0);
      chk("div_pair", 64'(stk_pair), 64'd1);
      chk("div_q1", 64'(stk_q1), 64'h0F_0000_0100);
      chk("div_q2", 64'(stk_q2), 64'h0C_0000_0100);
      clock_accept();
      chk("div_push_off", 64'(stk_push), 64'd0);
      chk("div_req_ready", 64'(bus.req_ready), 64'd0);
      chk("div_tmask", 64'(bus.rsp_tmask), 64'b0011);
      chk("div_diverged", 64'(bus.rsp_diverged), 64'd1);
      chk("div_redirect", 64'(bus.rsp_redirect), 64'd0);
      take_rsp("div");

      // Join to the else path
      stk_index = 1'b0;
      stk_d     = 36'hC_0000_0100;
      present(IPDOM_OP_JOIN, 4'b0011, 4'b0000, 32'h0);
      chk("j1_pop", 64'(stk_pop), 64'd1);
      chk("j1_push", 64'(stk_push), 64'd0);
      clock_accept();
      chk("j1_pop_off", 64'(stk_pop), 64'd0);
      chk("j1_tmask", 64'(bus.rsp_tmask), 64'b1100);
      chk("j1_pc", 64'(bus.rsp_pc), 64'h100);
      chk("j1_redirect", 64'(bus.rsp_redirect), 64'd1);
      chk("j1_diverged", 64'(bus.rsp_diverged), 64'd0);
      take_rsp("j1");

      // Join to the reconvergence point
      stk_index = 1'b1;
      stk_d     = 36'hF_0000_0100;
      present(IPDOM_OP_JOIN, 4'b1100, 4'b0000, 32'h0);
      chk("j2_pop", 64'(stk_pop), 64'd1);
      clock_accept();
      chk("j2_tmask", 64'(bus.rsp_tmask), 64'b1111);
      chk("j2_pc", 64'(bus.rsp_pc), 64'h100);
      chk("j2_redirect", 64'(bus.rsp_redirect), 64'd0);
      take_rsp("j2");

      // Uniform not-taken split
      present(IPDOM_OP_SPLIT, 4'b1010, 4'b0000, 32'h200);
      chk("un_push", 64'(stk_push), 64'd1);
      chk("un_pair", 64'(stk_pair), 64'd0);
      chk("un_q1", 64'(stk_q1), 64'h0A_0000_0200);
      clock_accept();
      chk("un_tmask", 64'(bus.rsp_tmask), 64'b1010);
      chk("un_diverged", 64'(bus.rsp_diverged), 64'd0);
      chk("un_redirect", 64'(bus.rsp_redirect), 64'd0);
      take_rsp("un");

      // Uniform taken split
      present(IPDOM_OP_SPLIT, 4'b0110, 4'b1111, 32'h240);
      chk("ut_pair", 64'(stk_pair), 64'd0);
      clock_accept();
      chk("ut_tmask", 64'(bus.rsp_tmask), 64'b0110);
      chk("ut_diverged", 64'(bus.rsp_diverged), 64'd0);
      take_rsp("ut");

      // Overflow
      stk_full = 1'b1;
      present(IPDOM_OP_SPLIT, 4'b1111, 4'b0011, 32'h280);
      chk("ovf_push", 64'(stk_push), 64'd0);
      clock_accept();
      chk("ovf_err", 64'(err_overflow), 64'd1);
      chk("ovf_tmask", 64'(bus.rsp_tmask), 64'b1111);
      chk("ovf_diverged", 64'(bus.rsp_diverged), 64'd0);
      chk("ovf_redirect", 64'(bus.rsp_redirect), 64'd0);
      take_rsp("ovf");
      stk_full = 1'b0;

      // Underflow
      stk_empty = 1'b1;
      stk_d     = 36'h5_1234_5678;
      stk_index = 1'b0;
      present(IPDOM_OP_JOIN, 4'b1111, 4'b0000, 32'h0);
      chk("unf_pop", 64'(stk_pop), 64'd0);
      clock_accept();
      chk("unf_err", 64'(err_underflow), 64'd1);
      chk("unf_tmask", 64'(bus.rsp_tmask), 64'd0);
      chk("unf_pc", 64'(bus.rsp_pc), 64'd0);
      chk("unf_redirect", 64'(bus.rsp_redirect), 64'd0);
      take_rsp("unf");
      stk_empty = 1'b0;
      chk("sticky_ovf", 64'(err_overflow), 64'd1);
      chk("sticky_unf", 64'(err_underflow), 64'd1);

      // Backpressure: response held while a new request waits
      present(IPDOM_OP_SPLIT, 4'b0101, 4'b0100, 32'h300);
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
         chk("bp_tmask", 64'(bus.rsp_tmask), 64'b0100);
         chk("bp_diverged", 64'(bus.rsp_diverged), 64'd1);
         chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
         chk("bp_push", 64'(stk_push), 64'd0);
         chk("bp_pop", 64'(stk_pop), 64'd0);
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
      take_rsp("bp");

      // Reset while a response is pending
      present(IPDOM_OP_SPLIT, 4'b0011, 4'b0001, 32'h400);
      clock_accept();
      chk("rr_valid_pre", 64'(bus.rsp_valid), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rr_valid_async", 64'(bus.rsp_valid), 64'd0);
      chk("rr_err_ovf", 64'(err_overflow), 64'd0);
      chk("rr_err_unf", 64'(err_underflow), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rr_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rr_tmask", 64'(bus.rsp_tmask), 64'd0);
      @(posedge clk);
      #1;
      chk("rr_still_idle", 64'(bus.rsp_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
